// File: rtl/reg_uarttrigger.sv
// reg_uarttrigger: 8N1 UART receiver on the clk_usb register bus; pulses trig_out when the newest
// len bytes match a masked pattern. Define UARTTRIG_STATUS_EN to add match/framing-error counters.
module reg_uarttrigger #(
  parameter logic [5:0] UARTTRIG_CFG_ADDR     = 6'd57,
  parameter logic [5:0] UARTTRIG_PATTERN_ADDR = 6'd58,
  parameter logic [5:0] UARTTRIG_STATUS_ADDR  = 6'd59
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic [5:0]  reg_address,
  input  logic [15:0] reg_bytecnt,
  output logic [7:0]  reg_datao,
  input  logic [7:0]  reg_datai,
  input  logic [15:0] reg_size,
  input  logic        reg_read,
  input  logic        reg_write,
  input  logic        reg_addrvalid,
  input  logic [5:0]  reg_hypaddress,
  output logic [15:0] reg_hyplen,
  output logic        reg_stream,
  input  logic        rx_i,
  output logic        trig_out
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  genvar gi;

  logic [15:0] div_reg;
  logic [7:0]  len_cfg_reg;
  logic [7:0]  flags_reg;
  logic [7:0]  pat_mem [16];

  logic        cfg_wr;
  logic        pat_wr;
  logic        enable;
  logic        invert;
  logic [15:0] div_eff;
  logic [3:0]  len_eff;

  logic        unused_bus;
  assign unused_bus = ^{reg_size, reg_read};

  assign cfg_wr  = reg_write && reg_addrvalid && (reg_address == UARTTRIG_CFG_ADDR);
  assign pat_wr  = reg_write && reg_addrvalid && (reg_address == UARTTRIG_PATTERN_ADDR);
  assign enable  = flags_reg[0];
  assign invert  = flags_reg[1];
  assign div_eff = (div_reg < 16'd4) ? 16'd4 : div_reg;

  always_comb begin
    len_eff = len_cfg_reg[3:0];
    if (len_cfg_reg[3:0] == 4'd0) begin
      len_eff = 4'd1;
    end else if (len_cfg_reg[3:0] > 4'd8) begin
      len_eff = 4'd8;
    end
  end

  // Config bytes are stored raw so readback returns what was written; clamping happens above.
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      div_reg     <= 16'd833;
      len_cfg_reg <= 8'h01;
      flags_reg   <= 8'h00;
    end else if (cfg_wr) begin
      case (reg_bytecnt)
        16'd0:   div_reg[7:0]  <= reg_datai;
        16'd1:   div_reg[15:8] <= reg_datai;
        16'd2:   len_cfg_reg   <= reg_datai;
        16'd3:   flags_reg     <= reg_datai;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      for (int i = 0; i < 16; i++) pat_mem[i] <= 8'h00;
    end else if (pat_wr && (reg_bytecnt < 16'd16)) begin
      pat_mem[reg_bytecnt[3:0]] <= reg_datai;
    end
  end

  // Serial input conditioning
  logic rx_meta_reg;
  logic rx_sync_reg;
  logic rx_prev_reg;
  logic rx_line;
  logic start_edge;

  assign rx_line    = rx_sync_reg ^ invert;
  assign start_edge = rx_prev_reg & ~rx_line;

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      rx_meta_reg <= 1'b1;
      rx_sync_reg <= 1'b1;
      rx_prev_reg <= 1'b1;
    end else begin
      rx_meta_reg <= rx_i;
      rx_sync_reg <= rx_meta_reg;
      rx_prev_reg <= rx_line;
    end
  end

  // Frame decoder
  state_t      state_reg, state_next;
  logic [15:0] cnt_reg, cnt_next;
  logic [2:0]  bit_reg, bit_next;
  logic [7:0]  data_reg, data_next;
  logic        commit_now;
  logic        frame_err;
  logic        hist_clr;
  logic        cnt_expire;

  assign hist_clr   = !enable || cfg_wr;
  assign cnt_expire = (cnt_reg == 16'd1);

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      state_reg <= IDLE;
      cnt_reg   <= 16'd0;
      bit_reg   <= 3'd0;
      data_reg  <= 8'h00;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      data_reg  <= data_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    bit_next   = bit_reg;
    data_next  = data_reg;
    commit_now = 1'b0;
    frame_err  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start_edge) begin
          cnt_next   = div_eff >> 1;
          state_next = START;
        end
      end
      START: begin
        if (!cnt_expire) begin
          cnt_next = cnt_reg - 16'd1;
        end else if (rx_line) begin
          state_next = IDLE;
        end else begin
          cnt_next   = div_eff;
          bit_next   = 3'd0;
          state_next = DATA;
        end
      end
      DATA: begin
        if (!cnt_expire) begin
          cnt_next = cnt_reg - 16'd1;
        end else begin
          data_next = {rx_line, data_reg[7:1]};
          cnt_next  = div_eff;
          if (bit_reg == 3'd7) begin
            state_next = STOP;
          end else begin
            bit_next = bit_reg + 3'd1;
          end
        end
      end
      STOP: begin
        if (!cnt_expire) begin
          cnt_next = cnt_reg - 16'd1;
        end else begin
          commit_now = rx_line;
          frame_err  = !rx_line;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    // Disable or any config write aborts an in-flight frame.
    if (hist_clr) begin
      state_next = IDLE;
      commit_now = 1'b0;
      frame_err  = 1'b0;
    end
  end

  // Byte history, hist_reg[0] newest
  logic [7:0] hist_reg [8];
  logic [3:0] rxcount_reg;
  logic       commit_reg;

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      for (int i = 0; i < 8; i++) hist_reg[i] <= 8'h00;
      rxcount_reg <= 4'd0;
      commit_reg  <= 1'b0;
    end else if (hist_clr) begin
      for (int i = 0; i < 8; i++) hist_reg[i] <= 8'h00;
      rxcount_reg <= 4'd0;
      commit_reg  <= 1'b0;
    end else begin
      commit_reg <= commit_now;
      if (commit_now) begin
        hist_reg[0] <= data_reg;
        for (int i = 1; i < 8; i++) hist_reg[i] <= hist_reg[i-1];
        if (rxcount_reg != 4'd8) rxcount_reg <= rxcount_reg + 4'd1;
      end
    end
  end

  // Pattern byte k lines up with history entry len-1-k (pattern byte 0 is the oldest).
  logic [2:0] hist_idx [8];
  logic [7:0] byte_ok;
  logic       match;
  logic       trig_next;
  logic       trig_reg;

  for (gi = 0; gi < 8; gi++) begin : g_match
    assign hist_idx[gi] = 3'(len_eff - 4'd1 - 4'(gi));
    assign byte_ok[gi]  = (4'(gi) >= len_eff) ||
                          (((hist_reg[hist_idx[gi]] ^ pat_mem[gi]) & pat_mem[gi+8]) == 8'h00);
  end

  assign match     = (rxcount_reg >= len_eff) && (&byte_ok);
  assign trig_next = commit_reg && match && !hist_clr;

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      trig_reg <= 1'b0;
    end else begin
      trig_reg <= trig_next;
    end
  end

  assign trig_out   = trig_reg;
  assign reg_stream = 1'b0;

`ifdef UARTTRIG_STATUS_EN
  logic        status_wr;
  logic [15:0] match_cnt_reg;
  logic [7:0]  ferr_cnt_reg;

  assign status_wr = reg_write && reg_addrvalid && (reg_address == UARTTRIG_STATUS_ADDR);

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      match_cnt_reg <= 16'd0;
      ferr_cnt_reg  <= 8'd0;
    end else if (status_wr) begin
      match_cnt_reg <= 16'd0;
      ferr_cnt_reg  <= 8'd0;
    end else begin
      if (trig_next && (match_cnt_reg != 16'hFFFF)) match_cnt_reg <= match_cnt_reg + 16'd1;
      if (frame_err && (ferr_cnt_reg != 8'hFF)) ferr_cnt_reg <= ferr_cnt_reg + 8'd1;
    end
  end
`else
  logic unused_status;
  assign unused_status = ^UARTTRIG_STATUS_ADDR;
`endif

  always_comb begin
    reg_datao = 8'h00;
    if (reg_addrvalid && (reg_address == UARTTRIG_CFG_ADDR)) begin
      case (reg_bytecnt)
        16'd0:   reg_datao = div_reg[7:0];
        16'd1:   reg_datao = div_reg[15:8];
        16'd2:   reg_datao = len_cfg_reg;
        16'd3:   reg_datao = flags_reg;
        default: reg_datao = 8'h00;
      endcase
    end else if (reg_addrvalid && (reg_address == UARTTRIG_PATTERN_ADDR)) begin
      if (reg_bytecnt < 16'd16) reg_datao = pat_mem[reg_bytecnt[3:0]];
`ifdef UARTTRIG_STATUS_EN
    end else if (reg_addrvalid && (reg_address == UARTTRIG_STATUS_ADDR)) begin
      case (reg_bytecnt)
        16'd0:   reg_datao = match_cnt_reg[7:0];
        16'd1:   reg_datao = match_cnt_reg[15:8];
        16'd2:   reg_datao = ferr_cnt_reg;
        default: reg_datao = 8'h00;
      endcase
`endif
    end
  end

  always_comb begin
    reg_hyplen = 16'd0;
    if (reg_hypaddress == UARTTRIG_CFG_ADDR) begin
      reg_hyplen = 16'd4;
    end else if (reg_hypaddress == UARTTRIG_PATTERN_ADDR) begin
      reg_hyplen = 16'd16;
`ifdef UARTTRIG_STATUS_EN
    end else if (reg_hypaddress == UARTTRIG_STATUS_ADDR) begin
      reg_hyplen = 16'd3;
`endif
    end
  end

endmodule
